// File: rtl/gray_ptr_receiver.sv
// gray_ptr_receiver: brings a Gray-coded pointer from a foreign clock domain
// into clk, decodes it to binary and accumulates the pointer increments into
// a delta that a consumer drains through a valid/ready handshake.
//
// Handshake: delta_valid is high whenever delta is nonzero; a transfer happens
// on a rising edge where delta_valid && delta_ready. On that edge the
// accumulator restarts from the increment seen in the same cycle, so no step
// is dropped. delta keeps growing while the consumer stalls, and delta_ready
// has no effect while delta_valid is low.
module gray_ptr_receiver #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             locked,
    output logic [WIDTH-1:0] delta,
    output logic             delta_valid,
    input  logic             delta_ready,
    output logic             err_multibit,
    output logic             overflow,
    input  logic             err_clear,
    output logic             state_dbg
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0]    INIT_LAST = CW'(SYNC_STAGES);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_VAL   = '1;

    state_t           state, state_next;
    logic [CW-1:0]    init_cnt, init_cnt_next;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] bin_q, g_q;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] step, diff, base;
    logic [WIDTH:0]   sum;
    logic             multibit;
    logic             xfer;
    logic             err_q, err_next;
    logic             ovf_q, ovf_next;

    // Plain flop chain into the clk domain; nothing sits between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) dec[i] = ^(sync_out >> i);
    end

    // A legal Gray move changes at most one bit; diff & (diff-1) clears the
    // lowest set bit, so anything left over means two or more bits changed.
    assign diff     = sync_out ^ g_q;
    assign multibit = (diff & (diff - ONE)) != '0;
    assign step     = dec - bin_q;
    assign xfer     = delta_valid && delta_ready;
    assign base     = xfer ? '0 : acc;
    assign sum      = {1'b0, base} + {1'b0, step};

    // Next state, accumulator and sticky flags; new errors override err_clear.
    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        acc_next      = acc;
        err_next      = err_clear ? 1'b0 : err_q;
        ovf_next      = err_clear ? 1'b0 : ovf_q;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    init_cnt_next = init_cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (multibit) begin
                    acc_next = base;
                    err_next = 1'b1;
                end else if (sum[WIDTH]) begin
                    acc_next = MAX_VAL;
                    ovf_next = 1'b1;
                end else begin
                    acc_next = sum[WIDTH-1:0];
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // State, decoded pointer (updated every edge, also during INIT) and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            bin_q    <= '0;
            g_q      <= '0;
            acc      <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
            bin_q    <= dec;
            g_q      <= sync_out;
            acc      <= acc_next;
            err_q    <= err_next;
            ovf_q    <= ovf_next;
        end
    end

    assign bin_out      = bin_q;
    assign delta        = acc;
    assign delta_valid  = (acc != '0);
    assign locked       = (state == ST_RUN);
    assign err_multibit = err_q;
    assign overflow     = ovf_q;
    assign state_dbg    = state;

endmodule

// File: doc/gray_ptr_receiver.md
GRAY_PTR_RECEIVER -- requirements
Module: gray_ptr_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of the Gray-coded pointer and of all binary outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal range 2..4).
REQ-003 SHALL have input clk, 1 bit, rising-edge clock of the receiving domain.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input gray_in, WIDTH bits: Gray-coded pointer from a foreign clock domain, asynchronous to clk.
REQ-006 SHALL have output bin_out, WIDTH bits: decoded binary value of the synchronized pointer.
REQ-007 SHALL have output locked, 1 bit: high once the initial synchronization period has completed.
REQ-008 SHALL have output delta, WIDTH bits: number of pointer increments accumulated since the last transfer.
REQ-009 SHALL have output delta_valid, 1 bit: delta is nonzero and available.
REQ-010 SHALL have input delta_ready, 1 bit: the consumer accepts delta in this cycle.
REQ-011 SHALL have output err_multibit, 1 bit: sticky flag for an illegal Gray transition.
REQ-012 SHALL have output overflow, 1 bit: sticky flag for delta saturation.
REQ-013 SHALL have input err_clear, 1 bit: synchronous clear of err_multibit and overflow.

Function
REQ-014 SHALL pass gray_in through a chain of SYNC_STAGES flops; no logic between the stages.
REQ-015 SHALL decode the last sync stage to binary: bit i = XOR of Gray bits WIDTH-1 down to i.
REQ-016 SHALL register the decoded value into bin_q every edge, and drive bin_out = bin_q.
- Latency: SYNC_STAGES+1 edges from the first edge that samples a new gray_in to the change on bin_out.
REQ-017 SHALL register the last synchronized Gray value g_q alongside bin_q.
REQ-018 SHALL implement the FSM as follows:
- INIT: entered on reset; lasts exactly SYNC_STAGES+1 rising edges after reset deassertion; locked=0.
- RUN: entered after that; locked=1; remains in RUN until reset.
REQ-019 SHALL compute in RUN step = (decode(sync_out) - bin_q) mod 2^WIDTH; wrap-around is legal (binary 2^WIDTH-1 to 0 gives step 1).
REQ-020 SHALL in RUN treat a Hamming distance > 1 between sync_out and g_q as illegal:
- Set err_multibit.
- Do not accumulate the step.
- Still update bin_q and g_q (resynchronize).
REQ-021 SHALL in RUN on a legal cycle update acc to acc + step, saturating at 2^WIDTH-1; on saturation, set overflow.
REQ-022 SHALL drive delta = acc, and delta_valid = (acc != 0).
REQ-023 SHALL treat delta_valid && delta_ready as a transfer of the current delta; at that edge, acc <= step (legal cycle) or 0 (illegal cycle).
- Same-cycle increments are never lost.
REQ-024 SHALL let delta grow while delta_valid=1 and delta_ready=0; the transferred value is delta in the handshake cycle.
REQ-025 SHALL ignore delta_ready when delta_valid=0.
REQ-026 SHALL clear err_multibit and overflow on err_clear; a new error in the same cycle wins (flag stays set).
REQ-027 SHALL not accumulate steps or raise flags in INIT.
REQ-028 SHALL require the source to advance at most one increment per clk period; faster sources are outside scope and are flagged through REQ-020.

Reset
REQ-029 SHALL on reset, immediately and asynchronously, set:
- Sync chain, bin_q, g_q, acc: 0.
- bin_out, delta: 0.
- delta_valid, locked, err_multibit, overflow: 0.
- FSM: INIT.
REQ-030 SHALL, when reset is asserted mid-operation, discard pending delta and flags, and restart INIT after deassertion.

Verification (WIDTH=4, SYNC_STAGES=2)
REQ-031 SHALL cover: reset release with gray_in=0000 -> locked=0 for 2 edges, locked=1 after the 3rd edge; bin_out=0, delta_valid=0.
REQ-032 SHALL cover: locked, delta_ready=0, gray_in 0000,0001,0011,0010 one per cycle -> bin_out=3, delta=3, delta_valid=1, err_multibit=0.
REQ-033 SHALL cover: delta=3, delta_ready=1 in the same cycle as a legal step of 1 -> next cycle delta=1, delta_valid=1.
REQ-034 SHALL cover: gray_in 0000->0011 -> err_multibit=1, delta unchanged, bin_out=2; err_clear=1 for one cycle -> err_multibit=0.
REQ-035 SHALL cover: delta_ready=0, 17 legal increments from 0 including wrap 1000->0000 -> delta=15, overflow=1, err_multibit=0.
REQ-036 SHALL cover: reset pulse mid-run with delta=5, err_multibit=1 -> all outputs 0 without waiting for a clk edge; locked=1 again 3 edges after release.
